note_track_gen: RTL

NOTE_TRACK_GEN -- requirements
Module: note_track_gen

---
 rtl/note_track_gen.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/note_track_gen.sv
// ----------------------------------------------------------------------------
// note_track_gen
//
// A scrolling rhythm-game chart. Note rows are queued in a 4-deep FIFO and
// fed into a 15-row, 8-lane chart one row per scroll tick. Row 0 is the top
// of the screen and row 14 is the hit row. A player key press on a lane
// whose hit-row bit is set scores a hit and clears that bit. Bits that
// scroll off the hit row without being hit count as misses. The chart is
// also rendered. For each pixel, is_sr flags whether the pixel lies inside
// a drawn note.
//
// Ports
//   Clk          in   system clock, all state updates on the rising edge
//   Reset        in   synchronous active-high reset, overrides everything
//   start        in   pulse: clear chart/FIFO/scores and (re)enter RUN
//   song_end     in   pulse: no more notes will be pushed (RUN -> DRAIN)
//   scroll_tick  in   pulse: advance the chart by one row (RUN/DRAIN only)
//   note_valid   in   note-row push request
//   note_lanes   in   [7:0] note-row contents, bit k = lane k
//   note_ready   out  push accepted this cycle (FIFO not full)
//   keys         in   [7:0] raw asynchronous lane keys
//   DrawX, DrawY in   [9:0] current pixel coordinates
//   is_sr        out  [7:0] per-lane note-pixel flags (registered)
//   keyTrack     out  [7:0] synchronized key state
//   hit_count    out  [15:0] saturating hit counter
//   miss_count   out  [15:0] saturating miss counter
//   done         out  high in DONE state
// ----------------------------------------------------------------------------
module note_track_gen (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        song_end,
    input  logic        scroll_tick,
    input  logic        note_valid,
    input  logic [7:0]  note_lanes,
    output logic        note_ready,
    input  logic [7:0]  keys,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [7:0]  is_sr,
    output logic [7:0]  keyTrack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
    output logic        done
);

    localparam int NUM_ROWS = 15;
    localparam int HIT_ROW  = NUM_ROWS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        done_q;

    logic [7:0]  rows_q [NUM_ROWS];
    logic [7:0]  rows_d [NUM_ROWS];

    logic [7:0]  fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_addr;
    logic [2:0]  count_q, count_d;

    logic [7:0]  sync1_q;
    logic [7:0]  key_track_q;

    logic [15:0] hit_q, hit_d;
    logic [15:0] miss_q, miss_d;

    logic [7:0]  is_sr_q, is_sr_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       active;
    logic       tick;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic [7:0] hits;
    logic [7:0] misses;
    logic       rows_zero;

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    // A start wins over a tick in the same cycle: the chart is being cleared.
    assign tick       = active && scroll_tick && !start;
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign push       = note_valid && !fifo_full;
    assign pop        = tick && !fifo_empty;

    // The edge is detected one stage early (sync1 vs keyTrack), so a hit is
    // scored on the same edge where keyTrack rises.
    assign hits   = (active && !start) ? (sync1_q & ~key_track_q & rows_q[HIT_ROW]) : 8'h00;
    // Hits are resolved first, so a bit hit on a tick edge is not also a miss.
    assign misses = tick ? (rows_q[HIT_ROW] & ~hits) : 8'h00;

    // A start restarts the FIFO at slot 0 and may take a push in the same cycle.
    assign wr_addr = start ? 2'd0 : wr_ptr_q;

    always_comb begin
        rows_zero = 1'b1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rows_q[r] != 8'h00) rows_zero = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Chart, FIFO pointers and score next-state
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        rows_d   = rows_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hit_d    = hit_q;
        miss_d   = miss_q;

        if (start) begin
            for (int r = 0; r < NUM_ROWS; r++) rows_d[r] = 8'h00;
            wr_ptr_d = push ? 2'd1 : 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = push ? 3'd1 : 3'd0;
            hit_d    = '0;
            miss_d   = '0;
        end else begin
            if (tick) begin
                for (int r = HIT_ROW; r > 0; r--) rows_d[r] = rows_q[r-1];
                rows_d[0] = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
            end else begin
                rows_d[HIT_ROW] = rows_q[HIT_ROW] & ~hits;
            end

            wr_ptr_d = wr_ptr_q + {1'b0, push};
            rd_ptr_d = rd_ptr_q + {1'b0, pop};
            count_d  = count_q + {2'b00, push} - {2'b00, pop};
            hit_d    = sat_add(hit_q, popcount8(hits));
            miss_d   = sat_add(miss_q, popcount8(misses));
        end
    end

    // ------------------------------------------------------------------
    // Pixel renderer: one lane is 64 px wide, one row is 32 px tall, and a
    // note is drawn with a 4 px margin inside its cell.
    // ------------------------------------------------------------------
    logic       in_area;
    logic [8:0] x_off;
    logic [2:0] lane;
    logic [7:0] row_bits;

    assign in_area = (DrawX >= 10'd64) && (DrawX <= 10'd575) && (DrawY <= 10'd479);

    always_comb begin
        is_sr_d  = '0;
        row_bits = '0;
        // Inside the area DrawX-64 is 0..511, so nine bits carry it exactly.
        x_off    = DrawX[8:0] - 9'd64;
        lane     = x_off[8:6];
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (DrawY[9:5] == 5'(r)) row_bits = rows_q[r];
        end
        if (in_area &&
            (x_off[5:0] >= 6'd4) && (x_off[5:0] <= 6'd59) &&
            (DrawY[4:0] >= 5'd4) && (DrawY[4:0] <= 5'd27)) begin
            // Screen lane 0 on the left shows note bit 7.
            is_sr_d[3'd7 - lane] = row_bits[3'd7 - lane];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= S_RUN;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  state_q <= S_IDLE;
                S_RUN:   if (song_end) state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (fifo_empty && rows_zero) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NUM_ROWS; r++) rows_q[r] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sync1_q     <= '0;
            key_track_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            is_sr_q     <= '0;
        end else begin
            rows_q      <= rows_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sync1_q     <= keys;
            key_track_q <= sync1_q;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            is_sr_q     <= is_sr_d;
        end
    end

    // NOTE: FIFO storage has no reset; the count and pointers alone decide
    // which slots are meaningful, so stale data is never read.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            fifo_mem_q[wr_addr] <= note_lanes;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign note_ready = !fifo_full;
    assign is_sr      = is_sr_q;
    assign keyTrack   = key_track_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign done       = done_q;

endmodule
